muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_muldiv_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Each operation takes 32 iteration cycles plus one sign-fixup cycle, then writes HI/LO.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic        to_hi,
    output logic        to_lo,
    output logic [31:0] to_hi_data,
    output logic [31:0] to_lo_data
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_t;

    state_t      state, state_nxt;
    op_t         op_in;
    logic [5:0]  cnt;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic        div_zero;
    logic [31:0] rs_raw;
    logic [31:0] b_mag;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    logic        accept;
    logic        last_iter;
    logic        is_signed_in;
    logic        is_div_in;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_trial;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign op_in        = op_t'(op);
    assign is_signed_in = (op_in == OP_MULT) || (op_in == OP_DIV);
    assign is_div_in    = (op_in == OP_DIV) || (op_in == OP_DIVU);
    assign rs_mag       = (is_signed_in && rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
    assign rt_mag       = (is_signed_in && rt_data[31]) ? (~rt_data + 32'd1) : rt_data;
    assign accept       = (state == IDLE) && start && !cancel;
    assign last_iter    = (cnt == 6'd32);

    // Iteration and fixup arithmetic shared between the datapath and the DONE results
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_mag} : 33'd0);
        div_shift = {hi_reg, lo_reg[31]};
        div_trial = div_shift - {1'b0, b_mag};
        prod_fix  = neg_res ? (~{hi_reg, lo_reg} + 64'd1) : {hi_reg, lo_reg};
        quo_fix   = neg_res ? (~lo_reg + 32'd1) : lo_reg;
        rem_fix   = neg_rem ? (~hi_reg + 32'd1) : hi_reg;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment to avoid ordering races.
            state <= state_nxt;
        end
    end

    // Next-state logic; cancel wins over start in IDLE and aborts CALC
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !cancel) state_nxt = CALC;
            CALC:    if (cancel) state_nxt = IDLE;
                     else if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs; cancel in DONE suppresses the write strobes combinationally
    always_comb begin
        busy       = (state != IDLE);
        done       = (state == DONE) && !cancel;
        to_hi      = done;
        to_lo      = done;
        to_hi_data = (state == DONE) ? hi_reg : 32'd0;
        to_lo_data = (state == DONE) ? lo_reg : 32'd0;
    end

    // Datapath: hi_reg/lo_reg hold the partial product or remainder/quotient pair
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= 6'd0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            rs_raw   <= 32'd0;
            b_mag    <= 32'd0;
            hi_reg   <= 32'd0;
            lo_reg   <= 32'd0;
        end else if (accept) begin
            cnt      <= 6'd0;
            is_div   <= is_div_in;
            neg_res  <= is_signed_in && (rs_data[31] ^ rt_data[31]);
            neg_rem  <= is_signed_in && is_div_in && rs_data[31];
            div_zero <= is_div_in && (rt_data == 32'd0);
            rs_raw   <= rs_data;
            b_mag    <= rt_mag;
            hi_reg   <= 32'd0;
            lo_reg   <= rs_mag;
        end else if (state == CALC && !cancel) begin
            if (!last_iter) begin
                cnt <= cnt + 6'd1;
                if (!is_div) begin
                    hi_reg <= mul_sum[32:1];
                    lo_reg <= {mul_sum[0], lo_reg[31:1]};
                end else if (!div_trial[32]) begin
                    hi_reg <= div_trial[31:0];
                    lo_reg <= {lo_reg[30:0], 1'b1};
                end else begin
                    hi_reg <= div_shift[31:0];
                    lo_reg <= {lo_reg[30:0], 1'b0};
                end
            end else if (!is_div) begin
                hi_reg <= prod_fix[63:32];
                lo_reg <= prod_fix[31:0];
            end else if (div_zero) begin
                hi_reg <= rs_raw;
                lo_reg <= 32'hFFFF_FFFF;
            end else begin
                hi_reg <= rem_fix;
                lo_reg <= quo_fix;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed operations push expected HI/LO pairs,
// a negedge monitor pops and compares on every write-back pulse.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        cancel = 1'b0;
    logic        busy, done, to_hi, to_lo;
    logic [31:0] to_hi_data, to_lo_data;

    int n_checks = 0;
    int n_pass = 0;
    logic [63:0] exp_q[$];

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .cancel(cancel),
        .busy(busy), .done(done), .to_hi(to_hi), .to_lo(to_lo),
        .to_hi_data(to_hi_data), .to_lo_data(to_lo_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // Monitor: every write-back must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (to_hi || to_lo || done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_writeback", {to_hi_data, to_lo_data}, 64'hx);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("hi_lo_result", {to_hi_data, to_lo_data}, e);
                check("strobes", {61'd0, to_hi, to_lo, done}, 64'd7);
            end
        end
    end

    // Accept one operation at the next edge; scramble operands right after acceptance
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit expect_wb);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        if (expect_wb) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        rs_data = $urandom; rt_data = $urandom; op = 2'($urandom_range(0, 3));
    endtask

    // Full run with latency checks: write-back in cycle after edge N+33, idle after N+34
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        issue(o, a, b, exp, 1'b1);
        check({name, "_busy_start"}, {63'd0, busy}, 64'd1);
        repeat (32) @(posedge clk);
        #1;
        check({name, "_quiet_calc"}, {62'd0, busy, to_hi}, 64'd2);
        @(posedge clk);
        #1;
        check({name, "_wb_latency"}, {62'd0, to_hi, to_lo}, 64'd3);
        @(posedge clk);
        #1;
        check({name, "_busy_end"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #12;
        check("reset_outputs", {busy, done, to_hi, to_lo, to_hi_data, to_lo_data}, 68'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg",  MULT,  32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("mult_edge", MULT,  32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
        run_op("div_neg",   DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_ovf",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_op("div_negb",  DIV,   32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
        run_op("divu",      DIVU,  32'h0000_0064, 32'h0000_0007, 64'h0000_0002_0000_000E);
        run_op("divu_zero", DIVU,  32'h0000_0064, 32'h0000_0000, 64'h0000_0064_FFFF_FFFF);
        run_op("div_zero",  DIV,   32'hFFFF_FFFB, 32'h0000_0000, 64'hFFFF_FFFB_FFFF_FFFF);

        // start while busy is ignored: only one result may appear
        issue(MULTU, 32'd6, 32'd7, 64'd42, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; op = DIVU; rs_data = 32'd9; rt_data = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("busy_start_ignored", {63'd0, busy}, 64'd0);

        // cancel in CALC aborts without write-back, then immediate restart
        issue(DIVU, 32'd1000, 32'd10, 64'd0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check("cancel_calc_idle", {63'd0, busy}, 64'd0);
        run_op("after_cancel", DIVU, 32'd1000, 32'd10, 64'h0000_0000_0000_0064);

        // cancel in DONE suppresses the strobes that cycle
        issue(MULTU, 32'd2, 32'd2, 64'd0, 1'b0);
        repeat (33) @(posedge clk);
        #1;
        cancel = 1'b1;
        #1;
        check("cancel_done_strobes", {61'd0, to_hi, to_lo, done}, 64'd0);
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check("cancel_done_idle", {63'd0, busy}, 64'd0);

        // cancel and start together keep IDLE
        @(negedge clk);
        start = 1'b1; cancel = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; cancel = 1'b0;
        check("cancel_over_start", {63'd0, busy}, 64'd0);

        // asynchronous reset mid-operation
        issue(MULT, 32'hFFFF_FFFE, 32'd3, 64'd0, 1'b0);
        repeat (19) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("reset_mid_op", {busy, done, to_hi, to_lo, to_hi_data, to_lo_data}, 68'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_held", {busy, done, to_hi, to_lo, to_hi_data, to_lo_data}, 68'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op("after_reset", MULTU, 32'd3, 32'd5, 64'h0000_0000_0000_000F);

        repeat (2) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
